// File: rtl/uart_tx_sched.sv
// uart_tx_sched: baud/oversample strobe source and round-robin byte
// scheduler feeding the iCE40 UART transmitter.
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   req, data   per-requester request and byte (requester i on [8i+7:8i])
//   txbusy      transmitter busy status from the UART
//   bitxce      one-cycle strobe every DIVISOR clocks
//   load, d     one-cycle transmit load pulse and its byte
//   ack         one-hot acknowledge, coincident with load
//   grant_id    index of the last granted requester
//   active      high from LOAD until the byte leaves WAIT
module uart_tx_sched #(
    parameter int NREQ    = 4,
    parameter int DIVISOR = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    input  logic              txbusy,
    output logic              bitxce,
    output logic              load,
    output logic [7:0]        d,
    output logic [NREQ-1:0]   ack,
    output logic [2:0]        grant_id,
    output logic              active
);

    localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIVISOR - 1);
    localparam logic [2:0] GID_RST = 3'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            bitxce_q, bitxce_d;
    logic            load_q, load_d;
    logic [7:0]      d_q, d_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [2:0]      grant_id_q, grant_id_d;
    logic            active_q, active_d;

    logic            win_found;
    logic [2:0]      win_idx;

    // Free-running prescaler; the strobe is registered off the terminal
    // count, so it lands one cycle after the counter reads DIVISOR-1.
    always_comb begin
        bitxce_d = (cnt_q == CNT_MAX);
        cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end

    // Round-robin search starting just past the last grant.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_idx   = grant_id_q;
        cand      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(grant_id_q) + i) % NREQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = 3'(cand);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        load_d     = 1'b0;
        ack_d      = '0;
        d_d        = d_q;
        grant_id_d = grant_id_q;
        active_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found && !txbusy) begin
                    state_d    = LOAD;
                    load_d     = 1'b1;
                    ack_d      = NREQ'(1) << win_idx;
                    d_d        = data[int'(win_idx)*8 +: 8];
                    grant_id_d = win_idx;
                    active_d   = 1'b1;
                end
            end
            LOAD: begin
                state_d  = SETTLE;
                active_d = 1'b1;
            end
            // The UART raises txbusy a cycle after load; skip that cycle.
            SETTLE: begin
                state_d  = WAIT;
                active_d = 1'b1;
            end
            WAIT: begin
                if (txbusy) begin
                    active_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitxce_q   <= 1'b0;
            load_q     <= 1'b0;
            d_q        <= '0;
            ack_q      <= '0;
            grant_id_q <= GID_RST;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitxce_q   <= bitxce_d;
            load_q     <= load_d;
            d_q        <= d_d;
            ack_q      <= ack_d;
            grant_id_q <= grant_id_d;
            active_q   <= active_d;
        end
    end

    assign bitxce   = bitxce_q;
    assign load     = load_q;
    assign d        = d_q;
    assign ack      = ack_q;
    assign grant_id = grant_id_q;
    assign active   = active_q;

endmodule
